// File: rtl/vend_checkout_ctrl_if.sv
// rtl/vend_checkout_ctrl_if.sv - front-panel signal bundle between panel inputs, checkout controller and displays
interface vend_checkout_ctrl_if #(
  parameter int NUM_KEYS = 3,
  parameter int DIGITS   = 2
);
  logic [NUM_KEYS-1:0] key;
  logic                sel_valid;
  logic [7:0]          sel_code;
  logic                checkout;
  logic                cancel;
  logic                dispense_ack;
  logic [4*DIGITS-1:0] pay_bcd;
  logic [4*DIGITS-1:0] item_bcd;
  logic [4*DIGITS-1:0] change_bcd;
  logic                short_flag;
  logic                ovf_flag;
  logic                dispense_req;
  logic                refund_pulse;
  logic                busy;

  modport master (
    output key, sel_valid, sel_code, checkout, cancel, dispense_ack,
    input  pay_bcd, item_bcd, change_bcd, short_flag, ovf_flag, dispense_req, refund_pulse, busy
  );

  modport slave (
    input  key, sel_valid, sel_code, checkout, cancel, dispense_ack,
    output pay_bcd, item_bcd, change_bcd, short_flag, ovf_flag, dispense_req, refund_pulse, busy
  );
endinterface

// File: rtl/vend_checkout_ctrl.sv
// rtl/vend_checkout_ctrl.sv - coin/item checkout controller with key debounce, BCD totals and dispense handshake
module vend_checkout_ctrl #(
  parameter int                     NUM_KEYS        = 3,
  parameter logic [8*NUM_KEYS-1:0]  COIN_VALUES     = {8'd10, 8'd1, 8'd5},
  parameter int                     NUM_ITEMS       = 4,
  parameter logic [8*NUM_ITEMS-1:0] ITEM_PRICES     = {8'd10, 8'd8, 8'd5, 8'd3},
  parameter int                     DIGITS          = 2,
  parameter int                     DEBOUNCE_CYCLES = 1000000
) (
  input  logic               clock,
  input  logic               clr,
  vend_checkout_ctrl_if.slave io
);
  localparam int TW   = 4 * DIGITS;
  localparam int MAXV = 10 ** DIGITS - 1;
  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SHOP, DISPENSE} state_t;

  state_t              state_q, state_d;
  logic [NUM_KEYS-1:0] sync1_q, sync1_d, sync2_q, sync2_d, deb_q, deb_d, press;
  logic [CW-1:0]       cnt_q [NUM_KEYS];
  logic [CW-1:0]       cnt_d [NUM_KEYS];
  logic                sel_q, sel_d, chk_q, chk_d, cnl_q, cnl_d;
  logic [TW-1:0]       pay_q, pay_d, item_q, item_d, chg_lat_q, chg_lat_d;
  logic [TW-1:0]       pay_bcd_q, pay_bcd_d, item_bcd_q, item_bcd_d, chg_bcd_q, chg_bcd_d;
  logic                ovf_q, ovf_d, req_q, req_d, refund_q, refund_d, short_q, short_d;

  logic                sel_edge, chk_edge, cnl_edge, coin_ev, item_ev, item_ok, sat_any;
  int                  coin_sum, price, pay_sum, item_sum;
  logic [TW-1:0]       pay_sat, item_sat, chg_bin;

  function automatic logic [TW-1:0] to_bcd(input logic [TW-1:0] v);
    logic [TW-1:0] r;
    int            rem;
    r   = '0;
    rem = int'(v);
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(rem % 10);
      rem         = rem / 10;
    end
    return r;
  endfunction

  always_comb begin
    sync1_d  = io.key;
    sync2_d  = sync1_q;
    deb_d    = deb_q;
    press    = '0;
    coin_sum = 0;
    // Counter reloads in the same edge that the synchronised value changes.
    for (int k = 0; k < NUM_KEYS; k++) begin
      cnt_d[k] = cnt_q[k];
      if (sync1_q[k] != sync2_q[k]) cnt_d[k] = CW'(DEBOUNCE_CYCLES);
      else if (cnt_q[k] != '0)      cnt_d[k] = cnt_q[k] - CW'(1);
      if (cnt_q[k] == CW'(1) && sync2_q[k] != deb_q[k]) begin
        deb_d[k] = sync2_q[k];
        press[k] = ~sync2_q[k];
      end
      if (press[k]) coin_sum = coin_sum + int'(COIN_VALUES[8*k +: 8]);
    end

    sel_d    = io.sel_valid;
    chk_d    = io.checkout;
    cnl_d    = io.cancel;
    sel_edge = io.sel_valid & ~sel_q;
    chk_edge = io.checkout & ~chk_q;
    cnl_edge = io.cancel & ~cnl_q;

    item_ok = 1'b0;
    price   = 0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (io.sel_code == 8'(i + 1)) begin
        item_ok = 1'b1;
        price   = int'(ITEM_PRICES[8*i +: 8]);
      end
    end

    coin_ev  = |press;
    item_ev  = sel_edge & item_ok;
    pay_sum  = int'(pay_q) + coin_sum;
    item_sum = int'(item_q) + price;
    pay_sat  = (pay_sum > MAXV) ? TW'(MAXV) : TW'(pay_sum);
    item_sat = (item_sum > MAXV) ? TW'(MAXV) : TW'(item_sum);
    sat_any  = (coin_ev && pay_sum > MAXV) || (item_ev && item_sum > MAXV);

    state_d   = state_q;
    pay_d     = pay_q;
    item_d    = item_q;
    chg_lat_d = chg_lat_q;
    ovf_d     = ovf_q;
    req_d     = req_q;
    refund_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ovf_d = 1'b0;
        if (coin_ev || item_ev) begin
          if (coin_ev) pay_d = pay_sat;
          if (item_ev) item_d = item_sat;
          ovf_d   = sat_any;
          state_d = SHOP;
        end
      end
      SHOP: begin
        if (cnl_edge) begin
          refund_d = 1'b1;
          pay_d    = '0;
          item_d   = '0;
          state_d  = IDLE;
        end else if (chk_edge && item_q != '0 && pay_q >= item_q) begin
          chg_lat_d = pay_q - item_q;
          req_d     = 1'b1;
          state_d   = DISPENSE;
        end else begin
          if (coin_ev) pay_d = pay_sat;
          if (item_ev) item_d = item_sat;
          ovf_d = ovf_q | sat_any;
        end
      end
      DISPENSE: begin
        if (io.dispense_ack) begin
          req_d   = 1'b0;
          pay_d   = '0;
          item_d  = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // While dispensing, the display shows the change latched at checkout.
    chg_bin    = (state_q == DISPENSE) ? chg_lat_q : ((pay_q >= item_q) ? pay_q - item_q : '0);
    pay_bcd_d  = to_bcd(pay_q);
    item_bcd_d = to_bcd(item_q);
    chg_bcd_d  = to_bcd(chg_bin);
    short_d    = item_q > pay_q;
  end

  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      sync1_q    <= '1;
      sync2_q    <= '1;
      deb_q      <= '1;
      for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= '0;
      sel_q      <= 1'b0;
      chk_q      <= 1'b0;
      cnl_q      <= 1'b0;
      pay_q      <= '0;
      item_q     <= '0;
      chg_lat_q  <= '0;
      ovf_q      <= 1'b0;
      req_q      <= 1'b0;
      refund_q   <= 1'b0;
      short_q    <= 1'b0;
      pay_bcd_q  <= '0;
      item_bcd_q <= '0;
      chg_bcd_q  <= '0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= cnt_d[k];
      sel_q      <= sel_d;
      chk_q      <= chk_d;
      cnl_q      <= cnl_d;
      pay_q      <= pay_d;
      item_q     <= item_d;
      chg_lat_q  <= chg_lat_d;
      ovf_q      <= ovf_d;
      req_q      <= req_d;
      refund_q   <= refund_d;
      short_q    <= short_d;
      pay_bcd_q  <= pay_bcd_d;
      item_bcd_q <= item_bcd_d;
      chg_bcd_q  <= chg_bcd_d;
    end
  end

  assign io.pay_bcd      = pay_bcd_q;
  assign io.item_bcd     = item_bcd_q;
  assign io.change_bcd   = chg_bcd_q;
  assign io.short_flag   = short_q;
  assign io.ovf_flag     = ovf_q;
  assign io.dispense_req = req_q;
  assign io.refund_pulse = refund_q;
  assign io.busy         = (state_q == DISPENSE);
endmodule

// File: tb/tb_vend_checkout_ctrl.sv
// tb/tb_vend_checkout_ctrl.sv - randomized self-checking bench for vend_checkout_ctrl against a behavioural till model
module tb_vend_checkout_ctrl;
  localparam int          NK     = 3;
  localparam int          NI     = 4;
  localparam int          DG     = 2;
  localparam int          DB     = 16;
  localparam int          SETTLE = DB + 8;
  localparam logic [23:0] COINS  = {8'd10, 8'd1, 8'd5};
  localparam logic [31:0] PRICES = {8'd10, 8'd8, 8'd5, 8'd3};

  logic clock = 1'b0;
  logic clr   = 1'b1;
  int   errors = 0;
  int   checks = 0;

  int coin_val [NK]   = '{5, 1, 10};
  int price_of [NI+1] = '{0, 3, 5, 8, 10};
  int m_pay, m_item;
  bit m_ovf, m_shop;

  vend_checkout_ctrl_if #(.NUM_KEYS(NK), .DIGITS(DG)) bus ();

  vend_checkout_ctrl #(
    .NUM_KEYS(NK), .COIN_VALUES(COINS), .NUM_ITEMS(NI), .ITEM_PRICES(PRICES),
    .DIGITS(DG), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock(clock),
    .clr  (clr),
    .io   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic logic [25:0] expected();
    int chg;
    chg = (m_pay >= m_item) ? m_pay - m_item : 0;
    return {bcd(m_pay), bcd(m_item), bcd(chg), m_item > m_pay, m_ovf};
  endfunction

  function automatic logic [25:0] observed();
    return {bus.pay_bcd, bus.item_bcd, bus.change_bcd, bus.short_flag, bus.ovf_flag};
  endfunction

  function automatic void m_add_coin(input int k);
    m_pay = m_pay + coin_val[k];
    if (m_pay > 99) begin m_pay = 99; m_ovf = 1'b1; end
    m_shop = 1'b1;
  endfunction

  function automatic void m_add_item(input int code);
    if (code >= 1 && code <= NI) begin
      m_item = m_item + price_of[code];
      if (m_item > 99) begin m_item = 99; m_ovf = 1'b1; end
      m_shop = 1'b1;
    end
  endfunction

  function automatic void m_clear();
    m_pay = 0; m_item = 0; m_ovf = 1'b0; m_shop = 1'b0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press_key(input int k);
    bus.key[k] = 1'b0; tick(SETTLE);
    bus.key[k] = 1'b1; tick(SETTLE);
    m_add_coin(k);
  endtask

  task automatic select_item(input int code);
    bus.sel_code = 8'(code); bus.sel_valid = 1'b1; tick(1);
    bus.sel_valid = 1'b0; tick(3);
    m_add_item(code);
  endtask

  task automatic pulse_checkout();
    bus.checkout = 1'b1; tick(1);
    bus.checkout = 1'b0; tick(2);
  endtask

  task automatic cancel_now(output bit refund_seen);
    bus.cancel = 1'b1; tick(1);
    refund_seen = bus.refund_pulse;
    bus.cancel = 1'b0; tick(3);
    if (m_shop) m_clear();
  endtask

  task automatic test_reset();
    clr = 1'b1; bus.key = '1; bus.sel_valid = 1'b0; bus.sel_code = 8'd0;
    bus.checkout = 1'b0; bus.cancel = 1'b0; bus.dispense_ack = 1'b0;
    m_clear();
    tick(2);
    checks++;
    if ({observed(), bus.dispense_req, bus.refund_pulse, bus.busy} !== 29'd0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", {observed(), bus.dispense_req, bus.refund_pulse, bus.busy});
    end
    clr = 1'b0; tick(3);
    checks++;
    if ({observed(), bus.dispense_req, bus.refund_pulse, bus.busy} !== 29'd0) begin
      errors++; $display("FAIL idle_outputs: got %h want 0", {observed(), bus.dispense_req, bus.refund_pulse, bus.busy});
    end
  endtask

  task automatic test_latency();
    bus.key[0] = 1'b0;
    tick(DB + 2);
    checks++;
    if (bus.pay_bcd !== 8'h00) begin errors++; $display("FAIL latency_early: got %h want 00", bus.pay_bcd); end
    tick(1);
    checks++;
    if (bus.pay_bcd !== 8'h05) begin errors++; $display("FAIL latency_exact: got %h want 05", bus.pay_bcd); end
    bus.key[0] = 1'b1; tick(SETTLE);
    m_add_coin(0);
    checks++;
    if (observed() !== expected()) begin errors++; $display("FAIL latency_totals: got %h want %h", observed(), expected()); end
  endtask

  task automatic test_chatter();
    bit r;
    cancel_now(r);
    checks++;
    if (r !== 1'b1) begin errors++; $display("FAIL chatter_pre_cancel_refund: got %b want 1", r); end
    for (int i = 0; i < 8; i++) begin bus.key[1] = ~bus.key[1]; tick(1); end
    bus.key[1] = 1'b0; tick(SETTLE);
    bus.key[1] = 1'b1; tick(SETTLE);
    m_add_coin(1);
    checks++;
    if (bus.pay_bcd !== 8'h01 || observed() !== expected()) begin
      errors++; $display("FAIL chatter_single_coin: got %h want %h", observed(), expected());
    end
  endtask

  task automatic test_checkout();
    bit r;
    cancel_now(r);
    press_key(0); press_key(0); press_key(1);
    select_item(2); select_item(1);
    checks++;
    if (observed() !== expected()) begin errors++; $display("FAIL checkout_totals: got %h want %h", observed(), expected()); end
    pulse_checkout();
    checks++;
    if ({bus.dispense_req, bus.busy, bus.item_bcd, bus.change_bcd} !== {1'b1, 1'b1, 8'h08, 8'h03}) begin
      errors++; $display("FAIL checkout_dispense: got %h want %h", {bus.dispense_req, bus.busy, bus.item_bcd, bus.change_bcd}, {1'b1, 1'b1, 8'h08, 8'h03});
    end
    bus.key[2] = 1'b0; tick(SETTLE); bus.key[2] = 1'b1;
    bus.cancel = 1'b1; tick(1);
    checks++;
    if ({bus.refund_pulse, bus.pay_bcd, bus.change_bcd, bus.dispense_req} !== {1'b0, 8'h11, 8'h03, 1'b1}) begin
      errors++; $display("FAIL dispense_ignores_events: got %h want %h", {bus.refund_pulse, bus.pay_bcd, bus.change_bcd, bus.dispense_req}, {1'b0, 8'h11, 8'h03, 1'b1});
    end
    bus.cancel = 1'b0; tick(SETTLE);
    bus.dispense_ack = 1'b1; tick(1);
    checks++;
    if (bus.dispense_req !== 1'b0) begin errors++; $display("FAIL ack_drops_req: got %b want 0", bus.dispense_req); end
    bus.dispense_ack = 1'b0; tick(2);
    m_clear();
    checks++;
    if ({observed(), bus.busy} !== {expected(), 1'b0}) begin
      errors++; $display("FAIL ack_clears: got %h want %h", {observed(), bus.busy}, {expected(), 1'b0});
    end
  endtask

  task automatic test_short();
    bit r;
    press_key(0); select_item(4);
    pulse_checkout();
    checks++;
    if ({bus.short_flag, bus.dispense_req, bus.busy} !== 3'b100) begin
      errors++; $display("FAIL short_no_dispense: got %b want 100", {bus.short_flag, bus.dispense_req, bus.busy});
    end
    checks++;
    if (observed() !== expected()) begin errors++; $display("FAIL short_totals: got %h want %h", observed(), expected()); end
    cancel_now(r);
    checks++;
    if (r !== 1'b1) begin errors++; $display("FAIL short_stays_shop: refund got %b want 1", r); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 10; i++) press_key(2);
    checks++;
    if (bus.pay_bcd !== 8'h99 || bus.ovf_flag !== 1'b1 || observed() !== expected()) begin
      errors++; $display("FAIL saturate: got %h want %h", observed(), expected());
    end
    bus.cancel = 1'b1; tick(1);
    checks++;
    if ({bus.refund_pulse, bus.ovf_flag} !== 2'b11) begin
      errors++; $display("FAIL cancel_refund_ovf: got %b want 11", {bus.refund_pulse, bus.ovf_flag});
    end
    bus.cancel = 1'b0; tick(1);
    checks++;
    if ({bus.refund_pulse, bus.pay_bcd, bus.item_bcd, bus.ovf_flag} !== 18'd0) begin
      errors++; $display("FAIL cancel_cleared: got %h want 0", {bus.refund_pulse, bus.pay_bcd, bus.item_bcd, bus.ovf_flag});
    end
    tick(2);
    m_clear();
  endtask

  task automatic test_cancel_checkout();
    press_key(0); select_item(1);
    bus.cancel = 1'b1; bus.checkout = 1'b1; tick(1);
    checks++;
    if ({bus.refund_pulse, bus.dispense_req, bus.busy} !== 3'b100) begin
      errors++; $display("FAIL cancel_wins: got %b want 100", {bus.refund_pulse, bus.dispense_req, bus.busy});
    end
    bus.cancel = 1'b0; bus.checkout = 1'b0; tick(3);
    m_clear();
    checks++;
    if ({observed(), bus.dispense_req} !== {expected(), 1'b0}) begin
      errors++; $display("FAIL cancel_wins_totals: got %h want %h", {observed(), bus.dispense_req}, {expected(), 1'b0});
    end
  endtask

  task automatic test_clr_dispense();
    press_key(0); select_item(1);
    pulse_checkout();
    checks++;
    if (bus.dispense_req !== 1'b1) begin errors++; $display("FAIL clr_pre_req: got %b want 1", bus.dispense_req); end
    #2 clr = 1'b1;
    #1;
    checks++;
    if ({bus.dispense_req, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL clr_async_drop: got %b want 00", {bus.dispense_req, bus.busy});
    end
    @(negedge clock);
    clr = 1'b0; tick(2);
    m_clear();
    checks++;
    if (observed() !== expected()) begin errors++; $display("FAIL clr_totals: got %h want %h", observed(), expected()); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 14; n++) begin
      int op;
      bit go;
      op = $urandom_range(0, 4);
      if (op <= 2) begin
        press_key(op);
      end else if (op == 3) begin
        select_item($urandom_range(0, NI + 1));
      end else begin
        go = m_shop && m_item > 0 && m_pay >= m_item;
        pulse_checkout();
        checks++;
        if (bus.dispense_req !== go) begin
          errors++; $display("FAIL rand_checkout_req: step %0d got %b want %b", n, bus.dispense_req, go);
        end
        if (go) begin
          bus.dispense_ack = 1'b1; tick(1);
          bus.dispense_ack = 1'b0; tick(2);
          m_clear();
        end
      end
      checks++;
      if (observed() !== expected()) begin
        errors++; $display("FAIL rand_totals: step %0d op %0d got %h want %h", n, op, observed(), expected());
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_chatter();
    test_checkout();
    test_short();
    test_saturate();
    test_cancel_checkout();
    test_clr_dispense();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
